seq_divider: RTL



---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle for the sequential divider.
// master drives the operands and start, slave returns results and status.
interface seq_divider_if #(
    parameter int bw = 16
);
    logic              start;
    logic [2*bw-1:0]   A;
    logic [bw-1:0]     B;
    logic [bw-1:0]     quotient;
    logic [bw-1:0]     remainder;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic              overflow;

    modport master (
        output start, A, B,
        input  quotient, remainder, busy, done, div_zero, overflow
    );

    modport slave (
        input  start, A, B,
        output quotient, remainder, busy, done, div_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, 2*bw-bit dividend by bw-bit divisor.
// Retires one quotient bit per CALC cycle; defining DIV_RADIX4_EN cascades two
// restoring steps per cycle (bw must then be even). Divide-by-zero and
// quotient overflow are detected at accept and skip straight to DONE.
module seq_divider #(
    parameter int bw = 16
) (
    input  logic         CLK,
    input  logic         RESET,
    seq_divider_if.slave bus
);

`ifdef DIV_RADIX4_EN
    localparam int STEPS = bw / 2;
`else
    localparam int STEPS = bw;
`endif
    localparam int CW = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [bw:0]     r_r;        // partial remainder, one spare bit so the shift never truncates
    logic [bw-1:0]   r_q;        // dividend low half shifting out, quotient bits shifting in
    logic [bw-1:0]   r_b;
    logic [CW-1:0]   r_cnt;
    logic [bw-1:0]   r_quot;
    logic [bw-1:0]   r_rem;
    logic            r_dz;
    logic            r_ovf;
    logic [bw:0]     w_r_nx;
    logic [bw-1:0]   w_q_nx;
    logic            w_last;
    logic            w_busy;
    logic            w_done;

    // One restoring step: shift {R,Q} left, trial-subtract B, keep on non-negative.
    // The trial is formed one bit wider than R so its sign is explicit.
    function automatic logic [2*bw:0] f_step(input logic [bw:0]   r,
                                             input logic [bw-1:0] q,
                                             input logic [bw-1:0] b);
        logic [bw+1:0] t;
        t = {r, q[bw-1]} - {2'b00, b};
        if (!t[bw+1])
            return {t[bw:0], q[bw-2:0], 1'b1};
        else
            return {r[bw-1:0], q[bw-1], q[bw-2:0], 1'b0};
    endfunction

    // Next partial remainder/quotient for this CALC cycle.
    always_comb begin
        logic [bw:0]   w_r1;
        logic [bw-1:0] w_q1;
        w_r1 = '0;
        w_q1 = '0;
        {w_r1, w_q1} = f_step(r_r, r_q, r_b);
`ifdef DIV_RADIX4_EN
        {w_r_nx, w_q_nx} = f_step(w_r1, w_q1, r_b);
`else
        w_r_nx = w_r1;
        w_q_nx = w_q1;
`endif
    end

    assign w_last = (r_cnt == CW'(STEPS - 1));

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    // Next-state and status decode.
    always_comb begin
        w_state_nx = r_state;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.B == '0 || bus.A[2*bw-1:bw] >= bus.B)
                        w_state_nx = S_DONE;
                    else
                        w_state_nx = S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (w_last)
                    w_state_nx = S_DONE;
            end
            S_DONE: begin
                w_busy     = 1'b1;
                w_done     = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result/flag registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_r    <= '0;
            r_q    <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_b <= bus.B;
                        if (bus.B == '0) begin
                            r_dz   <= 1'b1;
                            r_ovf  <= 1'b0;
                            r_quot <= '1;
                            r_rem  <= '0;
                        end else if (bus.A[2*bw-1:bw] >= bus.B) begin
                            r_dz   <= 1'b0;
                            r_ovf  <= 1'b1;
                            r_quot <= '1;
                            r_rem  <= '0;
                        end else begin
                            r_dz  <= 1'b0;
                            r_ovf <= 1'b0;
                            r_r   <= {1'b0, bus.A[2*bw-1:bw]};
                            r_q   <= bus.A[bw-1:0];
                            r_cnt <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_r   <= w_r_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + 1'b1;
                    // Results are captured on the way into DONE so they are valid with done.
                    if (w_last) begin
                        r_quot <= w_q_nx;
                        r_rem  <= w_r_nx[bw-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_zero  = r_dz;
    assign bus.overflow  = r_ovf;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

endmodule
